// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encodings and the default operand width.
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } ctrlState_e;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder shared by the serial datapath. Purely combinational.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  // Sum and carry of one bit position.
  always_comb begin
    s  = a ^ b ^ cin;
    co = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller. One full-adder cell is stepped over
// the operands LSB first, one bit per clock, with the carry held in a flop.
// Results are published only when the last bit has been computed.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  ctrlState_e       stateReg;
  ctrlState_e       stateNext;
  logic [WIDTH-1:0] aShReg;
  logic [WIDTH-1:0] bShReg;
  logic [WIDTH-1:0] rShReg;
  logic [WIDTH-1:0] sumReg;
  logic [CntW-1:0]  bitCntReg;
  logic             carryReg;
  logic             coutReg;
  logic             ovfReg;

  logic [WIDTH-1:0] bLoad;
  logic             cellS;
  logic             cellCo;
  logic             lastBit;

  // Subtraction feeds the one's complement of B; the forced carry-in of 1
  // completes the two's complement.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : gBInv
      assign bLoad[gi] = b[gi] ^ sub;
    end
  endgenerate

  full_adder_cell uCell (
    .a   (aShReg[0]),
    .b   (bShReg[0]),
    .cin (carryReg),
    .s   (cellS),
    .co  (cellCo)
  );

  assign lastBit = (bitCntReg == LastCnt);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= S_IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state logic and status outputs decoded from the current state.
  always_comb begin
    stateNext = stateReg;
    busy      = 1'b0;
    done      = 1'b0;
    case (stateReg)
      S_IDLE: begin
        if (start) begin
          stateNext = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (lastBit) begin
          stateNext = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        stateNext = S_IDLE;
      end
      default: begin
        stateNext = S_IDLE;
      end
    endcase
  end

  // Datapath: operand capture, per-bit shift/carry update, and result
  // publication on the final bit only, so partial sums never reach outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      aShReg    <= '0;
      bShReg    <= '0;
      rShReg    <= '0;
      sumReg    <= '0;
      bitCntReg <= '0;
      carryReg  <= 1'b0;
      coutReg   <= 1'b0;
      ovfReg    <= 1'b0;
    end else begin
      case (stateReg)
        S_IDLE: begin
          if (start) begin
            aShReg    <= a;
            bShReg    <= bLoad;
            carryReg  <= sub ? 1'b1 : cin;
            bitCntReg <= '0;
          end
        end
        S_RUN: begin
          rShReg   <= {cellS, rShReg[WIDTH-1:1]};
          aShReg   <= {1'b0, aShReg[WIDTH-1:1]};
          bShReg   <= {1'b0, bShReg[WIDTH-1:1]};
          carryReg <= cellCo;
          if (lastBit) begin
            // carryReg here is the carry into the MSB.
            sumReg  <= {cellS, rShReg[WIDTH-1:1]};
            coutReg <= cellCo;
            ovfReg  <= carryReg ^ cellCo;
          end else begin
            bitCntReg <= bitCntReg + CntW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum  = sumReg;
  assign cout = coutReg;
  assign ovf  = ovfReg;

endmodule
